// File: rtl/sort_arbiter.sv
// Arbitrates NREQ requesters onto one shared sorter and returns the tagged result.
// Define SORT_ARB_RR_EN for round-robin arbitration; the default is fixed priority.
module sort_arbiter #(
    parameter int NREQ     = 4,
    parameter int SORT_LAT = 1,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     reqValid,
    input  logic [NREQ*64-1:0]  reqData,
    output logic [NREQ-1:0]     reqReady,
    output logic [63:0]         sortIn,
    output logic                sortEnable,
    input  logic [63:0]         sortOut,
    output logic                rspValid,
    output logic [63:0]         rspData,
    output logic [IDW-1:0]      rspId,
    input  logic                rspReady
);

    localparam int CW = ($clog2(SORT_LAT + 1) < 1) ? 1 : $clog2(SORT_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_sortIn;
    logic            r_sortEnable;
    logic            r_rspValid;
    logic [63:0]     r_rspData;
    logic [IDW-1:0]  r_rspId;

    logic [IDW-1:0]  w_gnt;
    logic            w_gnt_valid;
    logic            w_hs;
    logic [63:0]     w_sel_data;

`ifdef SORT_ARB_RR_EN
    logic [IDW-1:0]  r_ptr;

    always_comb begin
        int idx;
        idx         = 0;
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_gnt_valid && reqValid[idx]) begin
                w_gnt       = IDW'(idx);
                w_gnt_valid = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest valid index is the last writer.
    always_comb begin
        w_gnt       = '0;
        w_gnt_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (reqValid[k]) begin
                w_gnt       = IDW'(k);
                w_gnt_valid = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt == IDW'(k)) w_sel_data = reqData[64*k +: 64];
        end
    end

    // Gated with rst_n so reqReady reads 0 while reset is asserted.
    always_comb begin
        reqReady = '0;
        for (int k = 0; k < NREQ; k++) begin
            reqReady[k] = rst_n && (r_state == StIdle) && w_gnt_valid && (w_gnt == IDW'(k));
        end
    end

    assign w_hs = (r_state == StIdle) && w_gnt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_sortIn     <= '0;
            r_sortEnable <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspData    <= '0;
            r_rspId      <= '0;
`ifdef SORT_ARB_RR_EN
            r_ptr        <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_sortIn     <= w_sel_data;
                        r_rspId      <= w_gnt;
                        r_cnt        <= CW'(SORT_LAT);
                        r_sortEnable <= 1'b1;
                        r_state      <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        r_rspData    <= sortOut;
                        r_rspValid   <= 1'b1;
                        r_sortEnable <= 1'b0;
                        r_state      <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rspReady) begin
                        r_rspValid <= 1'b0;
`ifdef SORT_ARB_RR_EN
                        r_ptr      <= (r_rspId == IDW'(NREQ - 1)) ? '0 : r_rspId + 1'b1;
`endif
                        r_state    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign sortIn     = r_sortIn;
    assign sortEnable = r_sortEnable;
    assign rspValid   = r_rspValid;
    assign rspData    = r_rspData;
    assign rspId      = r_rspId;

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter: a SORT_LAT=1 instance plus a SORT_LAT=3 instance,
// each fed by a behavioural sorter with the matching register latency.
module tb_sort_arbiter;

    logic         clk;
    logic         rst_n;

    logic [3:0]   reqValid, reqReady;
    logic [255:0] reqData;
    logic [63:0]  sortIn, sortOut, rspData;
    logic         sortEnable, rspValid, rspReady;
    logic [1:0]   rspId;

    logic [3:0]   reqValid3, reqReady3;
    logic [255:0] reqData3;
    logic [63:0]  sortIn3, sortOut3, rspData3;
    logic         sortEnable3, rspValid3, rspReady3;
    logic [1:0]   rspId3;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_hs   = 0;

    sort_arbiter #(.NREQ(4), .SORT_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqData(reqData),
        .reqReady(reqReady), .sortIn(sortIn), .sortEnable(sortEnable), .sortOut(sortOut),
        .rspValid(rspValid), .rspData(rspData), .rspId(rspId), .rspReady(rspReady)
    );

    sort_arbiter #(.NREQ(4), .SORT_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .reqValid(reqValid3), .reqData(reqData3),
        .reqReady(reqReady3), .sortIn(sortIn3), .sortEnable(sortEnable3), .sortOut(sortOut3),
        .rspValid(rspValid3), .rspData(rspData3), .rspId(rspId3), .rspReady(rspReady3)
    );

    function automatic logic [63:0] sort8(input logic [63:0] w);
        logic [7:0]  b [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) b[i] = w[8*i +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (b[j] < b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Sorter models: input register chain of SORT_LAT stages, then a combinational sort.
    logic [63:0] s1_q;
    logic [63:0] s3_q [3];
    always @(posedge clk) begin
        s1_q    <= sortIn;
        s3_q[0] <= sortIn3;
        s3_q[1] <= s3_q[0];
        s3_q[2] <= s3_q[1];
    end
    assign sortOut  = sort8(s1_q);
    assign sortOut3 = sort8(s3_q[2]);

    always @(posedge clk) if (rspValid && rspReady) n_hs <= n_hs + 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] din  [4];
    logic [63:0] dexp [4];
    int          order [5];
    int          n;
    int          hs0;
    logic [63:0] keep_si;

    initial begin
        din[0] = 64'h0807060504030201; dexp[0] = 64'h0102030405060708;
        din[1] = 64'h1122334455667788; dexp[1] = 64'h1122334455667788;
        din[2] = 64'h0102030405060708; dexp[2] = 64'h0102030405060708;
        din[3] = 64'h00FF10EF20DF30CF; dexp[3] = 64'h00102030CFDFEFFF;
`ifdef SORT_ARB_RR_EN
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
`else
        order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0; order[4] = 0;
`endif
        for (int i = 0; i < 4; i++) reqData[64*i +: 64] = din[i];
        reqData3  = '0;
        reqData3[63:0] = 64'hFF00FF00FF00FF00;
        reqValid3 = 4'b0000;
        rspReady3 = 1'b1;

        // Reset state, with a request already pending
        rst_n    = 1'b0;
        reqValid = 4'b0100;
        rspReady = 1'b1;
        #22;
        check("rst_reqReady", 64'(reqReady), 64'h0);
        check("rst_sortIn", sortIn, 64'h0);
        check("rst_sortEnable", 64'(sortEnable), 64'h0);
        check("rst_rspValid", 64'(rspValid), 64'h0);
        check("rst_rspData", rspData, 64'h0);
        check("rst_rspId", 64'(rspId), 64'h0);
        #5 rst_n = 1'b1;
        #1;
        check("t1_reqReady", 64'(reqReady), 64'h4);

        // Single request from requester 2
        tick();
        reqValid = 4'b0000;
        check("t1_sortIn", sortIn, 64'h0102030405060708);
        check("t1_sortEnable", 64'(sortEnable), 64'h1);
        check("t1_reqReady_wait", 64'(reqReady), 64'h0);
        n = 0;
        while (!rspValid && n < 12) begin tick(); n++; end
        check("t1_latency", 64'(n), 64'd2);
        check("t1_rspData", rspData, 64'h0102030405060708);
        check("t1_rspId", 64'(rspId), 64'd2);
        check("t1_sortEnable_resp", 64'(sortEnable), 64'h0);
        tick();
        check("t1_rspValid_clr", 64'(rspValid), 64'h0);

        // All four held: grant order, throughput SORT_LAT+3
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        reqValid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("t2_grant%0d", g), 64'(reqReady), 64'(4'b0001 << order[g]));
            tick();
            n = 0;
            while (!rspValid && n < 12) begin tick(); n++; end
            check($sformatf("t2_lat%0d", g), 64'(n), 64'd2);
            check($sformatf("t2_id%0d", g), 64'(rspId), 64'(order[g]));
            check($sformatf("t2_data%0d", g), rspData, dexp[order[g]]);
            tick();
            check($sformatf("t2_rspclr%0d", g), 64'(rspValid), 64'h0);
        end

        // Back-pressure: rspReady low for 10 cycles in RESP
        reqValid = 4'b0010;
        rspReady = 1'b0;
        #1;
        check("t3_grant", 64'(reqReady), 64'h2);
        tick();
        reqValid = 4'b1111;
        keep_si  = sortIn;
        check("t3_sortIn", keep_si, din[1]);
        n = 0;
        while (!rspValid && n < 12) begin tick(); n++; end
        check("t3_latency", 64'(n), 64'd2);
        hs0 = n_hs;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t3_hold_valid", 64'(rspValid), 64'h1);
            check("t3_hold_data", rspData, dexp[1]);
            check("t3_hold_id", 64'(rspId), 64'd1);
            check("t3_hold_ready", 64'(reqReady), 64'h0);
            check("t3_hold_sortIn", sortIn, din[1]);
        end
        rspReady = 1'b1;
        reqValid = 4'b0000;
        tick();
        check("t3_rspValid_clr", 64'(rspValid), 64'h0);
        tick(); tick(); tick();
        check("t3_one_handshake", 64'(n_hs - hs0), 64'd1);

        // Asynchronous reset while in WAIT
        reqValid = 4'b1000;
        #1;
        check("t4_grant", 64'(reqReady), 64'h8);
        tick();
        reqValid = 4'b0000;
        check("t4_in_wait", 64'(sortEnable), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_sortIn", sortIn, 64'h0);
        check("t4_async_sortEnable", 64'(sortEnable), 64'h0);
        check("t4_async_rspData", rspData, 64'h0);
        check("t4_async_rspId", 64'(rspId), 64'h0);
        #3 rst_n = 1'b1;
        hs0 = n_hs;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t4_no_rsp", 64'(rspValid), 64'h0);
        end
        check("t4_no_handshake", 64'(n_hs - hs0), 64'd0);

        // Requester 1 drops before its grant; requester 3 is served instead
        reqValid = 4'b1011;
        rspReady = 1'b0;
        #1;
        check("t5_grant0", 64'(reqReady), 64'h1);
        tick();
        n = 0;
        while (!rspValid && n < 12) begin tick(); n++; end
        check("t5_id0", 64'(rspId), 64'd0);
        reqValid = 4'b1000;
        rspReady = 1'b1;
        tick();
        check("t5_grant3", 64'(reqReady), 64'h8);
        tick();
        reqValid = 4'b0000;
        n = 0;
        while (!rspValid && n < 12) begin tick(); n++; end
        check("t5_id3", 64'(rspId), 64'd3);
        check("t5_data3", rspData, dexp[3]);
        hs0 = n_hs;
        for (int c = 0; c < 6; c++) tick();
        check("t5_no_req1_rsp", 64'(n_hs - hs0), 64'd1);
        check("t5_idle_valid", 64'(rspValid), 64'h0);

        // SORT_LAT=3 instance
        reqValid3 = 4'b0001;
        #1;
        check("t6_grant", 64'(reqReady3), 64'h1);
        tick();
        reqValid3 = 4'b0000;
        n = 0;
        while (!rspValid3 && n < 12) begin tick(); n++; end
        check("t6_latency", 64'(n), 64'd4);
        check("t6_data", rspData3, 64'h00000000FFFFFFFF);
        check("t6_id", 64'(rspId3), 64'd0);
        tick();
        check("t6_rspclr", 64'(rspValid3), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
